// File: rtl/instr_encoder.sv
// Field-bundle to 16-bit instruction encoder with an output FIFO.
// Illegal ops are dropped and counted instead of being queued.
module instr_encoder #(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [2:0]                 in_op,
   input  logic [2:0]                 in_dr,
   input  logic [2:0]                 in_sr1,
   input  logic [2:0]                 in_sr2,
   input  logic                       in_imm_sel,
   input  logic [8:0]                 in_imm,
   input  logic [2:0]                 in_nzp,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [15:0]                out_instr,
   output logic                       err_pulse,
   output logic [7:0]                 err_cnt,
   output logic [$clog2(DEPTH):0]     level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] FULL = LW'(DEPTH);

   logic [15:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   logic [15:0] enc_word;
   logic        enc_legal;
   logic [5:0]  alu_src;
   logic        accept;
   logic        push;
   logic        pop;
   logic        bad;

   assign alu_src = in_imm_sel ? {1'b1, in_imm[4:0]}
                               : {3'b000, in_sr2};

   always_comb begin
      enc_word  = 16'h0000;
      enc_legal = 1'b1;
      unique case (1'b1)
         (in_op == 3'd0): enc_word = {4'b0001, in_dr, in_sr1, alu_src};
         (in_op == 3'd1): enc_word = {4'b0101, in_dr, in_sr1, alu_src};
         (in_op == 3'd2): enc_word = {4'b1001, in_dr, in_sr1, 6'h3F};
         (in_op == 3'd3): enc_word = {4'b0000, in_nzp, in_imm};
         (in_op == 3'd4): enc_word = {4'b1100, 3'b000, in_sr1, 6'h00};
         (in_op == 3'd5): enc_word = {4'b1110, in_dr, in_imm};
         default:         enc_legal = 1'b0;
      endcase
   end

   assign in_ready  = (level < FULL);
   assign out_valid = (level != '0);
   assign out_instr = out_valid ? mem[rd_ptr] : 16'h0000;

   assign accept = in_valid && in_ready;
   assign push   = accept && enc_legal;
   assign bad    = accept && !enc_legal;
   assign pop    = out_valid && out_ready;

   // Storage carries no reset; level gates every read.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= enc_word;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         level     <= '0;
         err_pulse <= 1'b0;
         err_cnt   <= 8'h00;
      end else begin
         err_pulse <= bad;
         if (bad && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'h01;
         end
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         unique case ({push, pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder.
// Expected words are queued at drive time and popped as the DUT emits.
module tb_instr_encoder;

   localparam int DEPTH = 4;
   localparam int LW = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [2:0]    in_op = '0;
   logic [2:0]    in_dr = '0;
   logic [2:0]    in_sr1 = '0;
   logic [2:0]    in_sr2 = '0;
   logic          in_imm_sel = 1'b0;
   logic [8:0]    in_imm = '0;
   logic [2:0]    in_nzp = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [15:0]   out_instr;
   logic          err_pulse;
   logic [7:0]    err_cnt;
   logic [LW-1:0] level;

   int checks = 0;
   int failures = 0;
   int pushed = 0;
   int popped = 0;
   logic [15:0] sb [$];

   instr_encoder #(.DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_op      (in_op),
      .in_dr      (in_dr),
      .in_sr1     (in_sr1),
      .in_sr2     (in_sr2),
      .in_imm_sel (in_imm_sel),
      .in_imm     (in_imm),
      .in_nzp     (in_nzp),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_instr  (out_instr),
      .err_pulse  (err_pulse),
      .err_cnt    (err_cnt),
      .level      (level)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] model(input logic [2:0] op,
      input logic [2:0] dr, input logic [2:0] s1, input logic [2:0] s2,
      input logic sel, input logic [8:0] imm, input logic [2:0] nzp);
      logic [5:0] src;
      src = sel ? {1'b1, imm[4:0]} : {3'b000, s2};
      case (op)
         3'd0:    return {4'h1, dr, s1, src};
         3'd1:    return {4'h5, dr, s1, src};
         3'd2:    return {4'h9, dr, s1, 6'h3F};
         3'd3:    return {4'h0, nzp, imm};
         3'd4:    return {4'hC, 3'b000, s1, 6'h00};
         default: return {4'hE, dr, imm};
      endcase
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Drive one bundle for one edge; queue its word if it will be taken.
   task automatic send(input logic [2:0] op, input logic [2:0] dr,
      input logic [2:0] s1, input logic [2:0] s2, input logic sel,
      input logic [8:0] imm, input logic [2:0] nzp,
      input logic [15:0] exp);
      in_op = op; in_dr = dr; in_sr1 = s1; in_sr2 = s2;
      in_imm_sel = sel; in_imm = imm; in_nzp = nzp;
      in_valid = 1'b1;
      if (in_ready && op < 3'd6) begin
         sb.push_back(exp);
         pushed++;
      end
      cyc();
      in_valid = 1'b0;
   endtask

   task automatic send_m(input logic [2:0] op, input logic [2:0] dr,
      input logic [2:0] s1, input logic [2:0] s2, input logic sel,
      input logic [8:0] imm, input logic [2:0] nzp);
      send(op, dr, s1, s2, sel, imm, nzp,
           model(op, dr, s1, s2, sel, imm, nzp));
   endtask

   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            check("unexpected_word", {16'h0, out_instr}, 32'hDEAD_BEEF);
         end else begin
            check("word", {16'h0, out_instr}, {16'h0, sb.pop_front()});
            popped++;
         end
      end
   end

   task automatic drain(input string tag);
      int n;
      out_ready = 1'b1;
      n = 0;
      while (sb.size() != 0 && n < 20) begin
         cyc();
         n++;
      end
      check(tag, sb.size(), 0);
      cyc();
   endtask

   typedef struct {
      logic [2:0]  op, dr, s1, s2;
      logic        sel;
      logic [8:0]  imm;
      logic [2:0]  nzp;
      logic [15:0] exp;
   } vec_t;

   vec_t vecs [6] = '{
      '{3'd0, 3'd1, 3'd2, 3'd3, 1'b0, 9'h1E0, 3'd7, 16'h1283},
      '{3'd0, 3'd1, 3'd2, 3'd6, 1'b1, 9'h01F, 3'd5, 16'h12BF},
      '{3'd2, 3'd4, 3'd5, 3'd6, 1'b1, 9'h0AA, 3'd1, 16'h997F},
      '{3'd4, 3'd5, 3'd7, 3'd3, 1'b1, 9'h1AB, 3'd7, 16'hC1C0},
      '{3'd5, 3'd0, 3'd6, 3'd2, 1'b1, 9'h005, 3'd4, 16'hE005},
      '{3'd3, 3'd6, 3'd1, 3'd5, 1'b1, 9'h1FE, 3'd2, 16'h05FE}
   };

   initial begin
      #1000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] cnt0;
      #3;
      check("rst_level", level, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_out_instr", out_instr, 0);
      check("rst_err", {err_pulse, err_cnt}, 0);
      @(negedge clk);
      rst_n = 1'b1;

      out_ready = 1'b1;
      foreach (vecs[i]) begin
         send(vecs[i].op, vecs[i].dr, vecs[i].s1, vecs[i].s2,
              vecs[i].sel, vecs[i].imm, vecs[i].nzp, vecs[i].exp);
      end
      drain("directed_drain");
      check("empty_instr", out_instr, 0);

      out_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         send_m(3'(i), 3'(i + 1), 3'(i + 2), 3'(i + 3), i[0], 9'(i * 37), 3'(i));
      end
      check("full_level", level, DEPTH);
      check("full_in_ready", in_ready, 0);
      send_m(3'd5, 3'd7, 3'd0, 3'd0, 1'b0, 9'h155, 3'd0);
      check("full_hold_level", level, DEPTH);
      check("full_head_stable", out_instr, sb[0]);
      cyc();
      check("full_head_stable2", out_instr, sb[0]);
      drain("fill_drain");
      check("drained_valid", out_valid, 0);
      check("drained_instr", out_instr, 0);

      out_ready = 1'b0;
      send_m(3'd0, 3'd3, 3'd4, 3'd5, 1'b0, 9'h0, 3'd0);
      send_m(3'd1, 3'd2, 3'd1, 3'd0, 1'b1, 9'h00A, 3'd0);
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         send_m(3'(i % 6), 3'(i), 3'(7 - i), 3'(i + 3), i[1],
                9'($urandom_range(0, 511)), 3'(i + 1));
         check("stream_level", level, 2);
      end
      drain("stream_drain");

      cnt0 = err_cnt;
      send(3'd6, 3'd1, 3'd1, 3'd1, 1'b0, 9'h0, 3'd0, 16'h0);
      check("ill_pulse", err_pulse, 1);
      check("ill_cnt", err_cnt, 32'(cnt0) + 1);
      check("ill_no_write", level, 0);
      cyc();
      check("ill_pulse_clear", err_pulse, 0);
      in_op = 3'd7;
      in_valid = 1'b1;
      for (int i = 0; i < 300; i++) cyc();
      in_valid = 1'b0;
      check("ill_sat", err_cnt, 255);
      check("ill_sat_level", level, 0);

      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         send_m(3'd5, 3'(i), 3'd0, 3'd0, 1'b0, 9'(i + 100), 3'd0);
      end
      check("pre_rst_level", level, 3);
      #2;
      rst_n = 1'b0;
      pushed -= sb.size();
      sb.delete();
      #1;
      check("arst_valid", out_valid, 0);
      check("arst_level", level, 0);
      check("arst_cnt", err_cnt, 0);
      check("arst_ready", in_ready, 1);
      check("arst_instr", out_instr, 0);
      @(negedge clk);
      rst_n = 1'b1;
      send_m(3'd3, 3'd0, 3'd0, 3'd0, 1'b0, 9'h123, 3'd6);
      check("post_rst_level", level, 1);
      drain("post_rst_drain");
      check("pop_count", popped, pushed);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
